// File: rtl/spi_controller_if.sv
// rtl/spi_controller_if.sv - request/response bus between a host and spi_controller
interface spi_controller_if;
    logic       start;
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic [7:0] rdata;

    modport master (output start, rw, addr, wdata, input busy, done, rdata);
    modport slave  (input start, rw, addr, wdata, output busy, done, rdata);
endinterface

// File: rtl/spi_controller.sv
// rtl/spi_controller.sv - SPI mode-0 initiator sending {rw, addr, data} frames, MSB first
module spi_controller #(
    parameter int CLK_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    spi_controller_if.slave  bus,
    input  logic             cipo,
    output logic             sclk,
    output logic             copi,
    output logic             ncs
);
    localparam int CW = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    bit_idx, bit_idx_n;
    logic [14:0]   shreg, shreg_n;
    logic [7:0]    shadow, shadow_n;
    logic [7:0]    rdata_q, rdata_n;
    logic          busy_q, busy_n;
    logic          done_q, done_n;
    logic          sclk_n, copi_n, ncs_n;

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.rdata = rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            shadow  <= '0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sclk    <= 1'b0;
            copi    <= 1'b0;
            ncs     <= 1'b1;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            shreg   <= shreg_n;
            shadow  <= shadow_n;
            rdata_q <= rdata_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
            sclk    <= sclk_n;
            copi    <= copi_n;
            ncs     <= ncs_n;
        end
    end

    // bit_idx names the bit whose high phase is current; it steps down on each rising SCLK
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        shadow_n  = shadow;
        rdata_n   = rdata_q;
        busy_n    = busy_q;
        done_n    = 1'b0;
        sclk_n    = sclk;
        copi_n    = copi;
        ncs_n     = ncs;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    shreg_n   = {bus.addr, bus.wdata};
                    copi_n    = bus.rw;
                    ncs_n     = 1'b0;
                    busy_n    = 1'b1;
                    bit_idx_n = 4'd15;
                    cnt_n     = '0;
                    shadow_n  = '0;
                    state_n   = SETUP;
                end
            end
            SETUP: begin
                if (cnt == CNT_LAST) begin
                    cnt_n   = '0;
                    sclk_n  = 1'b1;
                    state_n = SHIFT;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            SHIFT: begin
                if (cnt != CNT_LAST) begin
                    cnt_n = cnt + 1'b1;
                end else begin
                    cnt_n = '0;
                    if (sclk) begin
                        sclk_n = 1'b0;
                        if (bit_idx != 4'd0) begin
                            copi_n  = shreg[14];
                            shreg_n = {shreg[13:0], 1'b0};
                        end
                    end else if (bit_idx == 4'd0) begin
                        ncs_n   = 1'b1;
                        copi_n  = 1'b0;
                        state_n = GAP;
                    end else begin
                        sclk_n    = 1'b1;
                        bit_idx_n = bit_idx - 1'b1;
                        // rising edge for bits 7..0 of the frame
                        if (bit_idx <= 4'd8) begin
                            shadow_n = {shadow[6:0], cipo};
                        end
                    end
                end
            end
            GAP: begin
                if (cnt == CNT_LAST) begin
                    cnt_n   = '0;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    rdata_n = shadow;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_spi_controller.sv
// tb/tb_spi_controller.sv - scoreboard bench for spi_controller built with CLK_DIV 4 and 1
module tb_spi_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_controller_if bus4 ();
    spi_controller_if bus1 ();

    logic [1:0] cipo_b = 2'b00;
    wire  [1:0] sclk_w;
    wire  [1:0] copi_w;
    wire  [1:0] ncs_w;

    spi_controller #(.CLK_DIV(4)) dut4 (
        .clk(clk), .rst(rst), .bus(bus4),
        .cipo(cipo_b[0]), .sclk(sclk_w[0]), .copi(copi_w[0]), .ncs(ncs_w[0])
    );
    spi_controller #(.CLK_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1),
        .cipo(cipo_b[1]), .sclk(sclk_w[1]), .copi(copi_w[1]), .ncs(ncs_w[1])
    );

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int          idx;
        logic [15:0] word;
        logic [7:0]  rdata;
        int          ncs_len;
        int          lat;
        int          period;
    } exp_t;
    exp_t sb[$];

    // bus monitor and peripheral model, one slot per DUT
    logic [7:0]  resp [2];
    logic [1:0]  prev_sclk = 2'b00;
    logic [1:0]  prev_ncs  = 2'b11;
    logic [15:0] word [2];
    logic [7:0]  done_rdata [2];
    logic [1:0]  done_busy = 2'b00;
    int rise_cnt [2], fall_cnt [2], ncs_len [2], fall_cyc [2];
    int done_cnt [2], done_cyc [2], last_rise [2], min_gap [2], max_gap [2];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic [7:0] rd;
            logic       bz;
            rd = (i == 0) ? bus4.rdata : bus1.rdata;
            bz = (i == 0) ? bus4.busy : bus1.busy;
            if (prev_ncs[i] && !ncs_w[i]) begin
                fall_cyc[i] = cyc;
                ncs_len[i] = 1;
                rise_cnt[i] = 0;
                fall_cnt[i] = 0;
                word[i] = 16'h0;
                last_rise[i] = -1;
                min_gap[i] = 1 << 30;
                max_gap[i] = 0;
            end else if (!ncs_w[i]) begin
                ncs_len[i]++;
            end
            if (!prev_sclk[i] && sclk_w[i]) begin
                word[i] = {word[i][14:0], copi_w[i]};
                rise_cnt[i]++;
                if (last_rise[i] >= 0) begin
                    if (cyc - last_rise[i] < min_gap[i]) min_gap[i] = cyc - last_rise[i];
                    if (cyc - last_rise[i] > max_gap[i]) max_gap[i] = cyc - last_rise[i];
                end
                last_rise[i] = cyc;
            end
            if (prev_sclk[i] && !sclk_w[i]) begin
                fall_cnt[i]++;
                if (fall_cnt[i] >= 8 && fall_cnt[i] <= 15) cipo_b[i] = resp[i][15 - fall_cnt[i]];
            end
            if (bus4.done === 1'b1 && i == 0 || bus1.done === 1'b1 && i == 1) begin
                done_cnt[i]++;
                done_cyc[i] = cyc;
                done_rdata[i] = rd;
                done_busy[i] = bz;
            end
            prev_sclk[i] = sclk_w[i];
            prev_ncs[i] = ncs_w[i];
        end
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int idx, input logic r, input logic [6:0] a, input logic [7:0] w,
                            input logic [7:0] rdv, input int d);
        exp_t e;
        e.idx = idx;
        e.word = {r, a, w};
        e.rdata = rdv;
        e.ncs_len = 33 * d;
        e.lat = 34 * d + 1;
        e.period = 2 * d;
        sb.push_back(e);
    endtask

    task automatic send(input int idx, input logic r, input logic [6:0] a, input logic [7:0] w,
                        output int t0);
        if (idx == 0) begin
            bus4.start = 1'b1; bus4.rw = r; bus4.addr = a; bus4.wdata = w;
        end else begin
            bus1.start = 1'b1; bus1.rw = r; bus1.addr = a; bus1.wdata = w;
        end
        t0 = cyc;
        step();
        bus4.start = 1'b0;
        bus1.start = 1'b0;
    endtask

    task automatic wait_done(input int idx, input int base);
        int n = 0;
        while (done_cnt[idx] == base && n < 3000) begin
            step();
            n++;
        end
        check("done_seen", done_cnt[idx] - base, 1);
    endtask

    task automatic check_frame(input int t0);
        exp_t e;
        int   i;
        check("sb_entry", sb.size(), (sb.size() > 0) ? sb.size() : 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            i = e.idx;
            check("copi_word", 32'(word[i]), 32'(e.word));
            check("sclk_rises", rise_cnt[i], 16);
            check("ncs_fall_ofs", fall_cyc[i] - t0, 1);
            check("ncs_low_len", ncs_len[i], e.ncs_len);
            check("done_ofs", done_cyc[i] - t0, e.lat);
            check("rdata_at_done", 32'(done_rdata[i]), 32'(e.rdata));
            check("busy_at_done", 32'(done_busy[i]), 32'h0);
            check("sclk_min_period", min_gap[i], e.period);
            check("sclk_max_period", max_gap[i], e.period);
        end
    endtask

    initial begin
        int t0, t1, base;
        resp[0] = 8'h00;
        resp[1] = 8'h00;
        bus4.start = 1'b1; bus4.rw = 1'b1; bus4.addr = 7'h7F; bus4.wdata = 8'hFF;
        bus1.start = 1'b1; bus1.rw = 1'b1; bus1.addr = 7'h7F; bus1.wdata = 8'hFF;

        // reset held 3 cycles with start asserted
        repeat (3) step();
        check("rst_ncs", 32'(ncs_w[0]), 32'h1);
        check("rst_sclk", 32'(sclk_w[0]), 32'h0);
        check("rst_copi", 32'(copi_w[0]), 32'h0);
        check("rst_busy", 32'(bus4.busy), 32'h0);
        check("rst_done", 32'(bus4.done), 32'h0);
        check("rst_rdata", 32'(bus4.rdata), 32'h0);
        check("rst_ncs_d1", 32'(ncs_w[1]), 32'h1);
        rst = 1'b0;
        bus4.start = 1'b0;
        bus1.start = 1'b0;
        repeat (3) step();
        check("rst_start_ignored_busy", 32'(bus4.busy), 32'h0);
        check("rst_start_ignored_ncs", 32'(ncs_w[0]), 32'h1);

        // write frame 0x84A5
        resp[0] = 8'h00;
        push_exp(0, 1'b1, 7'h04, 8'hA5, 8'h00, 4);
        base = done_cnt[0];
        send(0, 1'b1, 7'h04, 8'hA5, t0);
        wait_done(0, base);
        check_frame(t0);
        repeat (20) step();
        check("single_done", done_cnt[0] - base, 1);

        // start pulses during a frame are dropped; held start gives back-to-back frames
        resp[0] = 8'h11;
        push_exp(0, 1'b1, 7'h2A, 8'hC3, 8'h11, 4);
        push_exp(0, 1'b1, 7'h2A, 8'hC3, 8'h11, 4);
        base = done_cnt[0];
        send(0, 1'b1, 7'h2A, 8'hC3, t0);
        for (int k = 1; k <= 100; k++) begin
            bus4.start = (k >= 5) && k[0];
            step();
        end
        bus4.start = 1'b1;
        wait_done(0, base);
        check_frame(t0);
        t1 = done_cyc[0];
        step();
        check("b2b_ncs_fall", fall_cyc[0] - t1, 1);
        bus4.start = 1'b0;
        base = done_cnt[0];
        wait_done(0, base);
        check_frame(t1);

        // read frame with peripheral returning 0x3C
        resp[0] = 8'h3C;
        push_exp(0, 1'b0, 7'h01, 8'h77, 8'h3C, 4);
        base = done_cnt[0];
        send(0, 1'b0, 7'h01, 8'h77, t0);
        wait_done(0, base);
        check_frame(t0);
        for (int k = 0; k < 4; k++) begin
            repeat (10) step();
            check("rdata_hold", 32'(bus4.rdata), 32'h3C);
        end

        // reset after the 7th rising SCLK edge
        resp[0] = 8'hE7;
        base = done_cnt[0];
        send(0, 1'b1, 7'h55, 8'h33, t0);
        for (int n = 0; n < 500 && rise_cnt[0] < 7; n++) step();
        check("rise7_reached", rise_cnt[0], 7);
        check("rdata_hold_midframe", 32'(bus4.rdata), 32'h3C);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_ncs", 32'(ncs_w[0]), 32'h1);
        check("abort_sclk", 32'(sclk_w[0]), 32'h0);
        check("abort_copi", 32'(copi_w[0]), 32'h0);
        check("abort_busy", 32'(bus4.busy), 32'h0);
        check("abort_done", 32'(bus4.done), 32'h0);
        check("abort_rdata", 32'(bus4.rdata), 32'h0);
        repeat (200) step();
        check("abort_no_done", done_cnt[0] - base, 0);
        resp[0] = 8'h5A;
        push_exp(0, 1'b1, 7'h00, 8'h01, 8'h5A, 4);
        base = done_cnt[0];
        send(0, 1'b1, 7'h00, 8'h01, t0);
        wait_done(0, base);
        check_frame(t0);

        // CLK_DIV=1 build
        resp[1] = 8'h96;
        push_exp(1, 1'b1, 7'h00, 8'hFF, 8'h96, 1);
        base = done_cnt[1];
        send(1, 1'b1, 7'h00, 8'hFF, t0);
        wait_done(1, base);
        check_frame(t0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
